// File: rtl/clock_core.sv
// clock_core: 24-hour time of day, alarm register and ringing FSM.
// Button levels are edge-detected into single set steps; a prescaler makes
// the one-second tick. Define SNOOZE_EN to add the snooze input and state.
module clock_core #(
    parameter int unsigned TICKS_PER_SEC = 1000,
    parameter int unsigned RING_SECS     = 60,
    parameter int unsigned SNOOZE_MIN    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       c_plus,
    input  logic       c_minus,
    input  logic       a_plus,
    input  logic       a_minus,
    input  logic       alarm_on,
`ifdef SNOOZE_EN
    input  logic       snooze,
`endif
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [4:0] al_hours,
    output logic [5:0] al_minutes,
    output logic       sec_pulse,
    output logic       ringing
);

    localparam int unsigned PW          = $clog2(TICKS_PER_SEC);
    localparam int unsigned SNOOZE_SECS = SNOOZE_MIN * 60;
    localparam int unsigned CNT_MAX     = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
    localparam int unsigned CW          = $clog2(CNT_MAX + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

`ifdef SNOOZE_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RING = 2'd1, SNOOZE = 2'd2} state_t;
`else
    typedef enum logic [0:0] {IDLE = 1'b0, RING = 1'b1} state_t;
`endif

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [PW-1:0] presc, presc_n;
    logic          c_plus_q, c_minus_q, a_plus_q, a_minus_q;
    logic          c_up, c_dn, c_set, a_up, a_dn, a_set, tick, match;
    logic          snooze_rise;
    logic [4:0]    hr_n, al_hr_n;
    logic [5:0]    min_n, sec_n, al_min_n;

    // Minute step forward with carry through hours (23:59 -> 00:00).
    function automatic logic [10:0] min_inc(input logic [4:0] h, input logic [5:0] m);
        logic [4:0] hn;
        logic [5:0] mn;
        hn = h;
        mn = m + 6'd1;
        if (m == 6'd59) begin
            mn = 6'd0;
            hn = (h == 5'd23) ? 5'd0 : h + 5'd1;
        end
        return {hn, mn};
    endfunction

    // Minute step backward with borrow through hours (00:00 -> 23:59).
    function automatic logic [10:0] min_dec(input logic [4:0] h, input logic [5:0] m);
        logic [4:0] hn;
        logic [5:0] mn;
        hn = h;
        mn = m - 6'd1;
        if (m == 6'd0) begin
            mn = 6'd59;
            hn = (h == 5'd0) ? 5'd23 : h - 5'd1;
        end
        return {hn, mn};
    endfunction

    // Rising-edge steps; opposing edges in the same cycle cancel.
    always_comb begin
        c_up  = (c_plus & ~c_plus_q) & ~(c_minus & ~c_minus_q);
        c_dn  = (c_minus & ~c_minus_q) & ~(c_plus & ~c_plus_q);
        c_set = c_up | c_dn;
        a_up  = (a_plus & ~a_plus_q) & ~(a_minus & ~a_minus_q);
        a_dn  = (a_minus & ~a_minus_q) & ~(a_plus & ~a_plus_q);
        a_set = a_up | a_dn;
        tick  = (presc == PRESC_LAST) & ~c_set;
    end

    // Next prescaler, time and alarm values.
    always_comb begin
        presc_n = c_set ? '0 : ((presc == PRESC_LAST) ? '0 : presc + PW'(1));
        {hr_n, min_n} = {hours, minutes};
        sec_n = seconds;
        if (c_up) begin
            {hr_n, min_n} = min_inc(hours, minutes);
            sec_n = 6'd0;
        end else if (c_dn) begin
            {hr_n, min_n} = min_dec(hours, minutes);
            sec_n = 6'd0;
        end else if (tick) begin
            if (seconds == 6'd59) begin
                sec_n = 6'd0;
                {hr_n, min_n} = min_inc(hours, minutes);
            end else begin
                sec_n = seconds + 6'd1;
            end
        end
        {al_hr_n, al_min_n} = {al_hours, al_minutes};
        if (a_up) begin
            {al_hr_n, al_min_n} = min_inc(al_hours, al_minutes);
        end else if (a_dn) begin
            {al_hr_n, al_min_n} = min_dec(al_hours, al_minutes);
        end
        // Only a natural second tick can hit the alarm; set steps never match.
        match = tick & ~a_set & alarm_on & (hr_n == al_hours) &
                (min_n == al_minutes) & (sec_n == 6'd0);
    end

`ifdef SNOOZE_EN
    logic snooze_q;
    assign snooze_rise = snooze & ~snooze_q;
`else
    assign snooze_rise = 1'b0;
`endif

    // Ringing FSM next state; the counter restarts on every state change.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (match) state_n = RING;
            end
            RING: begin
                if (a_set) begin
                    state_n = IDLE;
`ifdef SNOOZE_EN
                end else if (snooze_rise) begin
                    state_n = SNOOZE;
`endif
                end else if (tick) begin
                    if (cnt == CW'(RING_SECS - 1)) state_n = IDLE;
                    else                           cnt_n = cnt + CW'(1);
                end
            end
`ifdef SNOOZE_EN
            SNOOZE: begin
                if (a_set) begin
                    state_n = IDLE;
                end else if (tick) begin
                    if (cnt == CW'(SNOOZE_SECS - 1)) state_n = RING;
                    else                             cnt_n = cnt + CW'(1);
                end
            end
`endif
            default: state_n = IDLE;
        endcase
        if (!alarm_on) state_n = IDLE;
        if (state_n != state) cnt_n = '0;
    end

    // All state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hours      <= 5'd0;
            minutes    <= 6'd0;
            seconds    <= 6'd0;
            al_hours   <= 5'd7;
            al_minutes <= 6'd0;
            presc      <= '0;
            sec_pulse  <= 1'b0;
            ringing    <= 1'b0;
            state      <= IDLE;
            cnt        <= '0;
            c_plus_q   <= 1'b0;
            c_minus_q  <= 1'b0;
            a_plus_q   <= 1'b0;
            a_minus_q  <= 1'b0;
`ifdef SNOOZE_EN
            snooze_q   <= 1'b0;
`endif
        end else begin
            hours      <= hr_n;
            minutes    <= min_n;
            seconds    <= sec_n;
            al_hours   <= al_hr_n;
            al_minutes <= al_min_n;
            presc      <= presc_n;
            sec_pulse  <= tick;
            ringing    <= (state_n == RING);
            state      <= state_n;
            cnt        <= cnt_n;
            c_plus_q   <= c_plus;
            c_minus_q  <= c_minus;
            a_plus_q   <= a_plus;
            a_minus_q  <= a_minus;
`ifdef SNOOZE_EN
            snooze_q   <= snooze;
`endif
        end
    end

endmodule
